// File: rtl/ncc_pkg.sv
// ----------------------------------------------------------------------------
// ncc_pkg
//   Shared types for the NCC descriptor path.
//   - log2_t      : log2-encoded pixel {sign, int[4:0], frac[-1:-27]}
//   - PIX_PER_WORD: pixels packed into one 32-bit readback word
//   - rb_state_e  : descriptor readback FSM states
// ----------------------------------------------------------------------------
package ncc_pkg;

   typedef bit [5:-27] log2_t;

   localparam int PIX_PER_WORD = 4;

   typedef enum logic [1:0] {
      RB_IDLE = 2'd0,
      RB_SEND = 2'd1,
      RB_CSUM = 2'd2
   } rb_state_e;

endpackage

// File: rtl/ilog2.sv
// ----------------------------------------------------------------------------
// ilog2
//   Inverse of the load-path log2 encoder. The encoder stores
//   int = floor(log2(x)) and frac = x/2^int - 1, so the inverse is exact:
//   value = round((1 + frac) * 2^int).
// Ports:
//   i_int   in  5   integer part of the log2 code
//   i_frac  in  27  fractional part of the log2 code
//   o_value out 32  reconstructed linear value
// ----------------------------------------------------------------------------
module ilog2 (
   input  logic [4:0]  i_int,
   input  logic [26:0] i_frac,
   output logic [31:0] o_value
);

   localparam logic [58:0] ROUND_HALF = 59'd1 << 26;

   logic [58:0] w_shifted;

   // Mantissa 1.frac in Q1.27; a 31-bit left shift still fits in 59 bits.
   assign w_shifted = {31'd0, 1'b1, i_frac} << i_int;
   assign o_value   = 32'((w_shifted + ROUND_HALF) >> 27);

endmodule

// File: rtl/pixel_unpack.sv
// ----------------------------------------------------------------------------
// pixel_unpack
//   Converts one log2_t descriptor code back to an 8-bit pixel.
//   Negative codes read as 0x00, values above 255 saturate to 0xFF.
//   The all-zero code reads as 0x01 (log2(0) and log2(1) share a code).
// Ports:
//   i_code  in  33  log2-encoded pixel
//   o_pixel out 8   unpacked pixel
// ----------------------------------------------------------------------------
module pixel_unpack
   import ncc_pkg::*;
(
   input  log2_t       i_code,
   output logic [7:0]  o_pixel
);

   logic [31:0] w_value;

   ilog2 u_ilog2 (
      .i_int   (i_code[4:0]),
      .i_frac  (i_code[-1:-27]),
      .o_value (w_value)
   );

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      o_pixel = 8'h00;
      if (!i_code[5]) begin
         o_pixel = (w_value > 32'd255) ? 8'hFF : w_value[7:0];
      end
   end

endmodule

// File: rtl/desc_readback.sv
// ----------------------------------------------------------------------------
// desc_readback
//   Reads back the log2-encoded descriptor pixels of the NCC PE, converts
//   them to 8-bit pixels and streams them as 32-bit words (4 pixels each,
//   lowest pixel in [31:24]) on a valid/ready interface.
// Parameters:
//   NUM_PIXELS  pixels read back, multiple of 4
// Ports:
//   clk          in   1   clock
//   rst          in   1   asynchronous active-high reset
//   start        in   1   pulse: begin readback (ignored while busy)
//   descPixelIn  in   33 x NUM_PIXELS log2 pixels
//   out_data     out  32  packed word
//   out_valid    out  1   out_data valid
//   out_ready    in   1   consumer ready
//   busy         out  1   readback in progress
//   done         out  1   one-cycle completion pulse
// Configuration:
//   DESC_READBACK_CHECKSUM_EN  when defined, a trailing word holding the
//   32-bit wrapping sum of all data words is sent before completion.
// ----------------------------------------------------------------------------
module desc_readback
   import ncc_pkg::*;
#(
   parameter int NUM_PIXELS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  log2_t       descPixelIn [NUM_PIXELS],
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
);

   localparam int NUM_WORDS = NUM_PIXELS / PIX_PER_WORD;
   localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

   rb_state_e        r_state;
   logic [CNT_W-1:0] r_word;
   logic [31:0]      r_data;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
`ifdef DESC_READBACK_CHECKSUM_EN
   logic [31:0]      r_csum;
`endif

   logic             w_handshake;
   logic             w_last;
   logic [CNT_W-1:0] w_sel;
   logic [7:0]       w_pixel [PIX_PER_WORD];
   logic [31:0]      w_word;

   assign w_handshake = r_valid & out_ready;
   assign w_last      = (r_word == LAST_WORD);

   // Word to register on the next load: word 0 from idle, otherwise the one
   // after the word currently presented. Holds at the last word (no wrap).
   always_comb begin
      w_sel = r_word;
      if (r_state == RB_IDLE) begin
         w_sel = '0;
      end else if (!w_last) begin
         w_sel = r_word + CNT_W'(1);
      end
   end

   for (genvar lane = 0; lane < PIX_PER_WORD; lane++) begin : g_lane
      pixel_unpack u_unpack (
         .i_code  (descPixelIn[{w_sel, 2'(lane)}]),
         .o_pixel (w_pixel[lane])
      );
   end

   assign w_word = {w_pixel[0], w_pixel[1], w_pixel[2], w_pixel[3]};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RB_IDLE;
         r_word  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef DESC_READBACK_CHECKSUM_EN
         r_csum  <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            RB_IDLE: begin
               if (start) begin
                  r_state <= RB_SEND;
                  r_word  <= '0;
                  r_data  <= w_word;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
`ifdef DESC_READBACK_CHECKSUM_EN
                  r_csum  <= w_word;
`endif
               end
            end
            RB_SEND: begin
               if (w_handshake) begin
                  if (!w_last) begin
                     r_word <= w_sel;
                     r_data <= w_word;
`ifdef DESC_READBACK_CHECKSUM_EN
                     r_csum <= r_csum + w_word;
`endif
                  end else begin
`ifdef DESC_READBACK_CHECKSUM_EN
                     // r_csum already includes the last data word.
                     r_state <= RB_CSUM;
                     r_data  <= r_csum;
`else
                     r_state <= RB_IDLE;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
`endif
                  end
               end
            end
            RB_CSUM: begin
               if (w_handshake) begin
                  r_state <= RB_IDLE;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= RB_IDLE;
         endcase
      end
   end

   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_desc_readback.sv
// ----------------------------------------------------------------------------
// tb_desc_readback
//   Directed self-checking bench for desc_readback (NUM_PIXELS = 64).
//   Honours DESC_READBACK_CHECKSUM_EN when the design is built with it.
// ----------------------------------------------------------------------------
module tb_desc_readback;
   import ncc_pkg::*;

   localparam int NUM_PIXELS = 64;
   localparam int NUM_WORDS  = NUM_PIXELS / 4;
`ifdef DESC_READBACK_CHECKSUM_EN
   localparam int TOTAL = NUM_WORDS + 1;
`else
   localparam int TOTAL = NUM_WORDS;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        out_ready;
   log2_t       desc_pixels [NUM_PIXELS];
   logic [31:0] out_data;
   logic        out_valid;
   logic        busy;
   logic        done;

   int          n_checks = 0;
   int          n_errors = 0;
   int          pix [NUM_PIXELS];
   logic [31:0] exp_words [TOTAL];

   always #5 clk = ~clk;

   desc_readback #(.NUM_PIXELS(NUM_PIXELS)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .descPixelIn (desc_pixels),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Load-path encoder: int = floor(log2 v), frac = v/2^int - 1.
   function automatic log2_t enc(input int v);
      int          k;
      logic [31:0] frac;
      if (v <= 1) return '0;
      k = 0;
      while ((v >> (k + 1)) != 0) k++;
      frac = 32'(v - (1 << k)) << (27 - k);
      return {1'b0, 5'(k), frac[26:0]};
   endfunction

   task automatic setup_vectors();
      logic [31:0] sum;
      for (int i = 0; i < NUM_PIXELS; i++) begin
         pix[i] = (i * 37 + 11) % 256;
         if (pix[i] < 1) pix[i] = 1;
      end
      pix[0] = 200; pix[1] = 128; pix[2] = 1; pix[3] = 255;
      for (int i = 0; i < NUM_PIXELS; i++) desc_pixels[i] = enc(pix[i]);
      // Negative code -> 0x00; 2^9 = 512 -> saturates to 0xFF.
      desc_pixels[8] = {1'b1, 5'd7, 27'd0};
      pix[8]         = 0;
      desc_pixels[9] = {1'b0, 5'd9, 27'd0};
      pix[9]         = 255;
      sum = '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
         exp_words[w] = {8'(pix[4*w]), 8'(pix[4*w+1]), 8'(pix[4*w+2]), 8'(pix[4*w+3])};
         sum = sum + exp_words[w];
      end
`ifdef DESC_READBACK_CHECKSUM_EN
      exp_words[NUM_WORDS] = sum;
`endif
   endtask

   // Full readback. Optional stall of stall_len cycles while word stall_at is
   // presented, a start pulse while busy, and a start on the final handshake.
   task automatic run_readback(input int stall_at, input int stall_len,
                               input int start_busy_at, input bit start_at_end);
      int          w;
      int          cyc;
      int          stalled;
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("w0_valid", 32'(out_valid), 32'd1);
      check("w0_busy", 32'(busy), 32'd1);
      check("w0_literal", out_data, 32'hC88001FF);
      w = 0; cyc = 0; stalled = 0;
      while (w < TOTAL && cyc < 200) begin
         cyc++;
         check($sformatf("data_w%0d", w), out_data, exp_words[w]);
         check($sformatf("valid_w%0d", w), 32'(out_valid), 32'd1);
         check($sformatf("busy_w%0d", w), 32'(busy), 32'd1);
         check($sformatf("done_low_w%0d", w), 32'(done), 32'd0);
         if (w == stall_at && stalled < stall_len) begin
            out_ready = 1'b0;
            stalled++;
         end else begin
            out_ready = 1'b1;
            if (w == start_busy_at) start = 1'b1;
            if (w == TOTAL - 1 && start_at_end) start = 1'b1;
            w++;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      if (w < TOTAL) check("timeout", 32'(w), 32'(TOTAL));
      check("done_pulse", 32'(done), 32'd1);
      check("busy_end", 32'(busy), 32'd0);
      check("valid_end", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("done_once", 32'(done), 32'd0);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      setup_vectors();
      #3;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data", out_data, 32'd0);
      #13 rst = 1'b0;

      // Idle without start: nothing happens.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("idle_nostart_valid", 32'(out_valid), 32'd0);
         check("idle_nostart_busy", 32'(busy), 32'd0);
         check("idle_nostart_done", 32'(done), 32'd0);
      end

      // Continuous ready, start while busy, start on final handshake.
      run_readback(-1, 0, 3, 1'b1);

      // Backpressure: 5-cycle stall on word 5.
      run_readback(5, 5, -1, 1'b0);

      // Reset while word 7 is presented.
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
      end
      check("abort_pre_w7", out_data, exp_words[7]);
      #2 rst = 1'b1;
      #1;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_data", out_data, 32'd0);
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("abort_no_done", 32'(done), 32'd0);
         check("abort_idle_valid", 32'(out_valid), 32'd0);
      end

      // Fresh readback after abort restarts from word 0.
      run_readback(-1, 0, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
